// File: rtl/rf_write_port_ctrl.sv
// rf_write_port_ctrl
// Write-side controller for the register file's single write port.
// ALU results always win the port and never stall; memory-load results wait
// in a small FIFO and drain in ALU bubbles. A younger ALU write to the same
// register supersedes any queued load to it: the load entry is invalidated in
// place and later pops as a bubble. pending_o lets the hazard logic see every
// register with a write still queued or currently on the write port.
module rf_write_port_ctrl #(
  parameter int raw   = 4,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid_i,
  input  logic [raw-1:0]        alu_addr_i,
  input  logic [7:0]            alu_data_i,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [raw-1:0]        ld_addr_i,
  input  logic [7:0]            ld_data_i,
  output logic                  wen_o,
  output logic [raw-1:0]        waddr_o,
  output logic [7:0]            wdata_o,
  output logic [(2**raw)-1:0]   pending_o,
  output logic [7:0]            squash_cnt_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int NREG = 2**raw;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Load FIFO storage; valid bits are separate from occupancy so superseded
  // entries can be dropped without compacting the queue.
  logic [raw-1:0]   mem_addr [DEPTH];
  logic [7:0]       mem_data [DEPTH];
  logic [DEPTH-1:0] mem_vld;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  logic             fifo_full;
  logic             fifo_empty;
  logic             ld_accept;
  logic             ld_squash;
  logic             do_enq;
  logic             do_pop;
  logic [DEPTH-1:0] squash_hit;
  logic [7:0]       squash_num;
  logic [8:0]       squash_sum;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign fifo_empty = (wr_ptr == rd_ptr);

  // ready depends only on registered pointers, so a full FIFO refuses a load
  // even in a cycle where it also pops.
  assign ld_ready_o = !fifo_full;
  assign ld_accept  = ld_valid_i && !fifo_full;

  // A load arriving with an ALU write to the same register is older and
  // therefore dead on arrival: handshake completes but nothing is queued.
  assign ld_squash  = alu_valid_i && ld_accept && (ld_addr_i == alu_addr_i);
  assign do_enq     = ld_accept && !ld_squash;
  assign do_pop     = !alu_valid_i && !fifo_empty;

  // Find queued loads superseded by this cycle's ALU write and count drops.
  always_comb begin
    squash_hit = '0;
    squash_num = {7'd0, ld_squash};
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_valid_i && mem_vld[i] && (mem_addr[i] == alu_addr_i)) begin
        squash_hit[i] = 1'b1;
        squash_num    = squash_num + 8'd1;
      end
    end
    squash_sum = {1'b0, squash_cnt_o} + {1'b0, squash_num};
  end

  // Pointer, valid-bit and squash-counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      mem_vld      <= '0;
      squash_cnt_o <= '0;
    end else begin
      mem_vld <= (mem_vld & ~squash_hit)
                 & ~(do_pop ? ({{(DEPTH-1){1'b0}}, 1'b1} << rd_idx) : '0)
                 | (do_enq ? ({{(DEPTH-1){1'b0}}, 1'b1} << wr_idx) : '0);
      if (do_enq) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      squash_cnt_o <= squash_sum[8] ? 8'hFF : squash_sum[7:0];
    end
  end

  // Payload storage; contents are don't-care until their valid bit is set.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem_addr[wr_idx] <= ld_addr_i;
      mem_data[wr_idx] <= ld_data_i;
    end
  end

  // Registered write port: ALU first, else the FIFO head. An invalidated
  // head pops as a bubble and leaves waddr/wdata untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wen_o   <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else if (alu_valid_i) begin
      wen_o   <= 1'b1;
      waddr_o <= alu_addr_i;
      wdata_o <= alu_data_i;
    end else if (do_pop) begin
      wen_o <= mem_vld[rd_idx];
      if (mem_vld[rd_idx]) begin
        waddr_o <= mem_addr[rd_idx];
        wdata_o <= mem_data[rd_idx];
      end
    end else begin
      wen_o <= 1'b0;
    end
  end

  // Pending mask from registered state only: the write on the port plus
  // every still-valid queued load.
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_vld[i]) begin
        pending_o[mem_addr[i]] = 1'b1;
      end
    end
    if (wen_o) begin
      pending_o[waddr_o] = 1'b1;
    end
  end

  // NREG documents the mask width; keep it tied to the port declaration.
  if (NREG != $bits(pending_o)) begin : g_width_guard
    $error("pending_o width does not match register count");
  end

endmodule

// File: tb/tb_rf_write_port_ctrl.sv
// Testbench for rf_write_port_ctrl: directed scenarios with fixed expectations
// followed by a randomized run against a queue-based reference model.
module tb_rf_write_port_ctrl;

  localparam int RAW   = 4;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [3:0]  alu_addr;
  logic [7:0]  alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        wen;
  logic [3:0]  waddr;
  logic [7:0]  wdata;
  logic [15:0] pending;
  logic [7:0]  squash_cnt;

  int checks;
  int errors;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    bit         v;
  } ent_t;

  rf_write_port_ctrl #(.raw(RAW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid_i  (alu_valid),
    .alu_addr_i   (alu_addr),
    .alu_data_i   (alu_data),
    .ld_valid_i   (ld_valid),
    .ld_ready_o   (ld_ready),
    .ld_addr_i    (ld_addr),
    .ld_data_i    (ld_data),
    .wen_o        (wen),
    .waddr_o      (waddr),
    .wdata_o      (wdata),
    .pending_o    (pending),
    .squash_cnt_o (squash_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit av, input logic [3:0] aa, input logic [7:0] ad,
                       input bit lv, input logic [3:0] la, input logic [7:0] ld);
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
    ld_valid  = lv;
    ld_addr   = la;
    ld_data   = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    ld_valid = 0; ld_addr = 0; ld_data = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (waddr !== 4'd0 || wdata !== 8'd0) begin
      errors++;
      $display("FAIL reset_addr_data: got %0h/%0h want 0/0", waddr, wdata);
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (wen !== 1'b0 || pending !== 16'h0 || ld_ready !== 1'b1 || squash_cnt !== 8'd0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: got wen=%b pend=%h rdy=%b sq=%0d want 0/0/1/0",
                 i, wen, pending, ld_ready, squash_cnt);
      end
    end
  endtask

  task automatic test_alu_write();
    apply_reset();
    drive(1, 4'd3, 8'h5A, 0, 0, 0);
    checks++;
    if (wen !== 1'b1 || waddr !== 4'd3 || wdata !== 8'h5A || pending !== 16'h0008) begin
      errors++;
      $display("FAIL alu_write: got wen=%b a=%0d d=%h pend=%h want 1/3/5a/0008",
               wen, waddr, wdata, pending);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (wen !== 1'b0 || pending !== 16'h0 || waddr !== 4'd3 || wdata !== 8'h5A) begin
      errors++;
      $display("FAIL alu_retire: got wen=%b pend=%h a=%0d d=%h want 0/0000/3/5a",
               wen, pending, waddr, wdata);
    end
  endtask

  task automatic test_fill_drain();
    logic [3:0] ea;
    logic [7:0] ed;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ld_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready%0d: got %b want 1", k, ld_ready);
      end
      drive(1, 4'd10, 8'(8'hA0 + k), 1, 4'(k + 1), 8'(8'h10 + k));
    end
    checks++;
    if (ld_ready !== 1'b0 || pending !== 16'h041E) begin
      errors++;
      $display("FAIL fill_full: got rdy=%b pend=%h want 0/041e", ld_ready, pending);
    end
    drive(1, 4'd10, 8'hA4, 1, 4'd5, 8'h55);
    checks++;
    if (ld_ready !== 1'b0 || pending !== 16'h041E || wen !== 1'b1 || waddr !== 4'd10) begin
      errors++;
      $display("FAIL fill_hold5: got rdy=%b pend=%h wen=%b a=%0d want 0/041e/1/10",
               ld_ready, pending, wen, waddr);
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, k < 2, 4'd5, 8'h55);
      ea = (k < 4) ? 4'(k + 1) : 4'd5;
      ed = (k < 4) ? 8'(8'h10 + k) : 8'h55;
      checks++;
      if (wen !== 1'b1 || waddr !== ea || wdata !== ed) begin
        errors++;
        $display("FAIL drain%0d: got wen=%b a=%0d d=%h want 1/%0d/%h", k, wen, waddr, wdata, ea, ed);
      end
      if (k == 0) begin
        checks++;
        if (ld_ready !== 1'b1) begin
          errors++;
          $display("FAIL drain_ready: got %b want 1", ld_ready);
        end
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (wen !== 1'b0 || pending !== 16'h0) begin
      errors++;
      $display("FAIL drain_end: got wen=%b pend=%h want 0/0000", wen, pending);
    end
  endtask

  task automatic test_squash();
    apply_reset();
    drive(1, 4'd9, 8'h77, 1, 4'd2, 8'h11);
    drive(1, 4'd9, 8'h78, 1, 4'd5, 8'h22);
    drive(1, 4'd2, 8'h99, 0, 0, 0);
    checks++;
    if (wen !== 1'b1 || waddr !== 4'd2 || wdata !== 8'h99 || squash_cnt !== 8'd1 || pending !== 16'h0024) begin
      errors++;
      $display("FAIL squash_alu: got wen=%b a=%0d d=%h sq=%0d pend=%h want 1/2/99/1/0024",
               wen, waddr, wdata, squash_cnt, pending);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (wen !== 1'b0 || pending !== 16'h0020) begin
      errors++;
      $display("FAIL squash_bubble: got wen=%b pend=%h want 0/0020", wen, pending);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (wen !== 1'b1 || waddr !== 4'd5 || wdata !== 8'h22 || squash_cnt !== 8'd1) begin
      errors++;
      $display("FAIL squash_r5: got wen=%b a=%0d d=%h sq=%0d want 1/5/22/1", wen, waddr, wdata, squash_cnt);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (wen !== 1'b0 || pending !== 16'h0) begin
      errors++;
      $display("FAIL squash_end: got wen=%b pend=%h want 0/0000", wen, pending);
    end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    drive(1, 4'd7, 8'h02, 1, 4'd7, 8'h01);
    checks++;
    if (wen !== 1'b1 || waddr !== 4'd7 || wdata !== 8'h02 || squash_cnt !== 8'd1 || pending !== 16'h0080) begin
      errors++;
      $display("FAIL same_cycle: got wen=%b a=%0d d=%h sq=%0d pend=%h want 1/7/02/1/0080",
               wen, waddr, wdata, squash_cnt, pending);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (wen !== 1'b0 || pending !== 16'h0 || waddr !== 4'd7 || wdata !== 8'h02) begin
        errors++;
        $display("FAIL same_cycle_after%0d: got wen=%b pend=%h a=%0d d=%h want 0/0000/7/02",
                 i, wen, pending, waddr, wdata);
      end
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 1; i <= 300; i++) begin
      drive(1, 4'd7, 8'(i), 1, 4'd7, 8'(i + 1));
      if (i == 200) begin
        checks++;
        if (squash_cnt !== 8'd200) begin
          errors++;
          $display("FAIL sat_mid: got %0d want 200", squash_cnt);
        end
      end
    end
    checks++;
    if (squash_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_end: got %0d want 255", squash_cnt);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 4'd12, 8'(8'hC0 + k), 1, 4'(k + 1), 8'(8'h30 + k));
    end
    checks++;
    if (wen !== 1'b1 || pending !== 16'h100E) begin
      errors++;
      $display("FAIL rstmid_pre: got wen=%b pend=%h want 1/100e", wen, pending);
    end
    #1 reset = 1'b1;
    alu_valid = 0; ld_valid = 0;
    #1;
    checks++;
    if (wen !== 1'b0 || pending !== 16'h0 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async: got wen=%b pend=%h rdy=%b want 0/0000/1", wen, pending, ld_ready);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (wen !== 1'b0 || pending !== 16'h0) begin
        errors++;
        $display("FAIL rstmid_stale%0d: got wen=%b pend=%h want 0/0000", i, wen, pending);
      end
    end
  endtask

  task automatic test_random();
    ent_t       q[$];
    ent_t       e;
    bit         m_wen;
    logic [3:0] m_addr;
    logic [7:0] m_data;
    int         m_sq;
    logic [15:0] m_pend;
    bit         av, lv, acc;
    logic [3:0] aa, la;
    logic [7:0] ad, ld;
    apply_reset();
    m_wen = 0; m_addr = 0; m_data = 0; m_sq = 0;
    for (int c = 0; c < 3000; c++) begin
      av = ($urandom_range(0, 9) < 4);
      lv = ($urandom_range(0, 9) < 6);
      aa = 4'($urandom_range(0, 5));
      la = 4'($urandom_range(0, 5));
      ad = 8'($urandom);
      ld = 8'($urandom);
      checks++;
      if (ld_ready !== (q.size() < DEPTH)) begin
        errors++;
        $display("FAIL rnd_ready c%0d: got %b want %b", c, ld_ready, q.size() < DEPTH);
      end
      acc = lv && (q.size() < DEPTH);
      if (av) begin
        foreach (q[i]) begin
          if (q[i].v && q[i].a == aa) begin
            q[i].v = 0;
            m_sq++;
          end
        end
        m_wen = 1; m_addr = aa; m_data = ad;
        if (acc) begin
          if (la == aa) m_sq++;
          else q.push_back('{a: la, d: ld, v: 1'b1});
        end
      end else begin
        if (q.size() > 0) begin
          e = q.pop_front();
          m_wen = e.v;
          if (e.v) begin
            m_addr = e.a; m_data = e.d;
          end
        end else begin
          m_wen = 0;
        end
        if (acc) q.push_back('{a: la, d: ld, v: 1'b1});
      end
      if (m_sq > 255) m_sq = 255;
      m_pend = '0;
      foreach (q[i]) if (q[i].v) m_pend[q[i].a] = 1'b1;
      if (m_wen) m_pend[m_addr] = 1'b1;
      drive(av, aa, ad, lv, la, ld);
      checks++;
      if (wen !== m_wen || waddr !== m_addr || wdata !== m_data) begin
        errors++;
        $display("FAIL rnd_port c%0d: got %b/%0d/%h want %b/%0d/%h", c, wen, waddr, wdata, m_wen, m_addr, m_data);
      end
      checks++;
      if (pending !== m_pend || squash_cnt !== 8'(m_sq)) begin
        errors++;
        $display("FAIL rnd_state c%0d: got pend=%h sq=%0d want %h/%0d", c, pending, squash_cnt, m_pend, m_sq);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    ld_valid = 0; ld_addr = 0; ld_data = 0;
    test_reset();
    test_alu_write();
    test_fill_drain();
    test_squash();
    test_same_cycle();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_port_ctrl.md
# rf_write_port_ctrl

Write-side controller for the 8-bit register file's single synchronous write port. Merges ALU results, which never stall, with memory-load results, which are buffered in a 4-entry FIFO, into one registered write per cycle. Exports a per-register pending mask so the decode/hazard logic can stall reads of registers with writes still in flight. Sits between the execute/memory stages and the register file's wen/write_addr/write_data inputs.

## Interface
- raw, 4, register-file address width; the register file has 2**raw registers
- DEPTH, 4, load FIFO depth; power of two, at least 2
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state immediately
- alu_valid_i  input  1  ALU result present this cycle; no backpressure
- alu_addr_i  input  raw  ALU destination register
- alu_data_i  input  8  ALU result
- ld_valid_i  input  1  load result offered
- ld_ready_o  output  1  load FIFO can accept; equals !full
- ld_addr_i  input  raw  load destination register
- ld_data_i  input  8  load data
- wen_o  output  1  to register file write enable; registered
- waddr_o  output  raw  to register file write address; registered
- wdata_o  output  8  to register file write data; registered
- pending_o  output  2**raw  bit r set while any write to register r is queued or on the output
- squash_cnt_o  output  8  saturating count of load writes discarded as superseded

## Operation
- Load accept: a load is accepted when ld_valid_i && ld_ready_o. It is enqueued at the FIFO tail unless it is dropped by the same-address rule below.
- Program order is fixed: every FIFO entry is older than any ALU result. A load presented in the same cycle as an ALU result is also older than that ALU result.
- Output selection each cycle, registered on the next edge:
  - alu_valid_i=1: the output register loads {1, alu_addr_i, alu_data_i}. The FIFO does not pop.
  - alu_valid_i=0 and FIFO not empty: the output register loads the head entry and the FIFO pops.
  - Otherwise: wen_o goes to 0. waddr_o and wdata_o hold their previous values.
- Squash rule, applied when alu_valid_i=1:
  - Every valid FIFO entry whose address equals alu_addr_i is invalidated in that cycle.
  - An accepted load in the same cycle with ld_addr_i == alu_addr_i is not enqueued. It still counts as accepted (handshake completes).
  - squash_cnt_o increments by the number of entries discarded that cycle, then saturates at 255.
- Invalidated entries stay in place and still occupy FIFO slots. When one reaches the head it pops without producing a write, taking a cycle in which wen_o=0. Full/empty are computed from the head/tail pointers, not from valid bits.
- pending_o bit r = (wen_o && waddr_o==r) OR (some valid FIFO entry has addr r). It is computed combinationally from registered state only and has no combinational path from the inputs.
- Pointers are log2(DEPTH) bits plus a wrap bit. full = addresses equal and wrap bits differ. empty = pointers fully equal.
- Enqueue and pop in the same cycle while full is permitted only if ld_ready_o was already 1. Because ld_ready_o = !full, a full FIFO accepts nothing that cycle even if it pops.

## Timing
- Reset values: wen_o=0, waddr_o=0, wdata_o=0, FIFO empty, ld_ready_o=1, pending_o=0, squash_cnt_o=0.
- ALU result: wen_o is asserted on the edge after alu_valid_i, and the register file commits it on the following edge. Latency from input to register-file update is 2 edges.
- Load on an empty FIFO with no ALU traffic: the load enqueues on edge 1 and appears on wen_o after edge 2.
- ld_ready_o deasserts the cycle after the FIFO becomes full. It reasserts the cycle after the first pop.
- With continuous ALU traffic the loads starve. This is by design; upstream guarantees ALU bubbles.
- Reset asserted mid-operation:
  - All queued loads are lost and the FIFO empties.
  - wen_o drops asynchronously, so no partial write reaches the register file.

## Test plan
- Reset then idle: wen_o=0, pending_o=0, ld_ready_o=1, squash_cnt_o=0 for 10 cycles.
- ALU write r3=0x5A in cycle 0: wen_o=1, waddr_o=3, wdata_o=0x5A in cycle 1; pending_o[3]=1 in cycle 1 only.
- Fill with 4 loads (r1..r4) while ALU is busy: ld_ready_o=0 after the 4th. The 5th load is held. When ALU goes idle the writes drain in order r1,r2,r3,r4 on consecutive cycles, and the 5th load is then accepted.
- Queue loads r2=0x11, r5=0x22, then ALU writes r2=0x99: the r2 load is squashed and squash_cnt_o=1. Output sequence is r2=0x99, then a bubble with wen_o=0, then r5=0x22. pending_o[2] clears after the ALU write retires.
- Same-cycle load r7=0x01 and ALU r7=0x02: only r7=0x02 is written, squash_cnt_o increments, and no load entry is enqueued.
- Assert reset while 3 loads are queued and wen_o=1: wen_o=0 immediately, the FIFO is empty after reset release, and no stale write appears.
